rlbp_seq: RTL and testbench
===========================

# rlbp_seq

Parametrised pixel-readout sequencer for the RLBP pixel array, on the Wishbone slave port of the user project. It generates the reset, integrate, sample-and-hold and compare phase strobes for the analog pixel macro. It also samples N_CH comparator outputs into a local-binary-pattern code register. Frames run single-shot or continuously, with programmable phase lengths, a frame counter, overrun detection and an interrupt.

## Interface
- N_CH, 12, comparator/pixel channels (1..32)
- BASE_ADR, 32'h3000_0000, Wishbone base; decode on adr[31:4], register select adr[3:2]
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic strobes
- wbs_sel_i  in  4  byte enables
- wbs_adr_i, wbs_dat_i  in  32  address / write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  acknowledge
- cmp_i  in  N_CH  asynchronous comparator outputs from the pixel macro
- sh_rst_o, sw1_o, sh_o, sw2_o, sh_cmp_o  out  1  phase strobes to the macro
- irq_o  out  1  interrupt, level

## Operation
- Registers (byte offsets):
  - 0x0 CTRL: [0] start (W1, self-clearing); [1] cont; [2] irq_en; [3] abort (W1, self-clearing).
  - 0x4 TIMING: [7:0] t_rst, [15:8] t_int, [23:16] t_sh, [31:24] t_cmp. Reset value 0x01010101.
  - 0x8 STATUS: [0] busy (RO); [1] done (sticky, W1C); [2] overrun (sticky, W1C); [31:16] frame_cnt (RO).
  - 0xC CODE: [N_CH-1:0] last code (RO), upper bits read 0.
- Register writes honour wbs_sel_i per byte.
- Reads of unmapped offsets inside the 16-byte window return 0 and are acked.
- Addresses outside the window are never acked.
- cmp_i passes through a 2-flop synchroniser per bit.
- FSM states: IDLE -> RST -> INT -> SH -> CMP -> (cont ? RST : IDLE).
  - Each active phase lasts max(t_x,1) cycles, counted by one 8-bit down-counter reloaded at each phase entry.
  - Strobes are registered, one-hot by state: RST→sh_rst_o, INT→sw1_o, SH→sh_o+sw2_o, CMP→sh_cmp_o.
  - All strobes are 0 in IDLE.
- In the last CMP cycle, on the frame-done edge:
  - the synchronised cmp_i is latched into CODE;
  - frame_cnt increments, wrapping 0xFFFF→0;
  - done is set.
  - If done was already 1 at that edge, overrun is also set. CODE is still overwritten.
- start in IDLE begins a frame. start while busy is ignored.
- Clearing cont mid-frame lets the current frame finish, then the FSM goes to IDLE.
- abort forces IDLE on the next edge from any state. There is no CODE, done or frame_cnt update.
- abort and start written together: abort wins.
- TIMING writes during a frame take effect at the next phase entry.
- W1C of done on the same edge as the frame-done event: set wins. Same rule for overrun.
- irq_o = done & irq_en.

## Timing
- Reset values:
  - all strobes 0, wbs_ack_o 0, wbs_dat_o 0, irq_o 0;
  - CTRL 0, STATUS 0, CODE 0;
  - TIMING 0x01010101; FSM IDLE.
- Wishbone: ack asserts one cycle after cyc&stb of a matched access, for exactly one cycle. No back-to-back ack on a held strobe: ack is deasserted for at least one cycle. Read data is valid with ack.
- A start write acked at edge n puts the FSM in RST at edge n+1. busy and sh_rst_o are high from n+1.
- Frame length = max(t_rst,1)+max(t_int,1)+max(t_sh,1)+max(t_cmp,1) cycles.
- CODE and done update on the same edge the FSM leaves CMP.
- cmp_i-to-CODE latency: 2 sync cycles. The input must be stable for 2 cycles before the CMP exit edge.
- Reset asserted mid-frame returns every output to its reset value immediately (asynchronous).

## Structure
- Shared package rlbp_pkg holds:
  - the state enum;
  - register offset constants;
  - TIMING and STATUS field positions;
  - the TIMING reset value.
- One sub-module, rlbp_wb_regs: Wishbone decode/ack, register file, W1C/self-clear logic. It exports the control fields and accepts the frame-done/code event.
- The FSM, phase counter and synchroniser live in rlbp_seq.

## Test plan
- Reset mid-frame -> all strobes, irq_o, STATUS and CODE read 0; TIMING reads 0x01010101.
- TIMING=0x01010302, cmp_i=12'hA5A, start -> sh_rst_o 2 cycles, sw1_o 3, sh_o 1, sh_cmp_o 1; CODE=0xA5A; frame_cnt=1; done=1.
- cont=1, irq_en=1, TIMING=0x01010101, done never cleared -> irq_o high after frame 1; overrun=1 after frame 2; frame_cnt=N after 4N cycles.
- Abort written during INT -> strobes 0 next cycle; CODE, done and frame_cnt unchanged; busy=0.
- TIMING=0 -> 4-cycle frame, each strobe 1 cycle.
- W1C of done on the frame-done edge -> done reads 1; read at offset 0x40 above base -> no ack.

Source files
------------

// File: rtl/rlbp_pkg.sv
// Shared types and constants for the RLBP pixel-readout sequencer.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package rlbp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RST  = 3'd1,
      ST_INT  = 3'd2,
      ST_SH   = 3'd3,
      ST_CMP  = 3'd4
   } state_t;

   // Phase strobes to the analog macro, one field per pin
   typedef struct packed {
      logic sh_rst;
      logic sw1;
      logic sh;
      logic sw2;
      logic sh_cmp;
   } strobes_t;

   // Register select values (wbs_adr_i[3:2])
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_TIMING = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CODE   = 2'd3;

   // CTRL bits
   localparam int CTRL_START  = 0;
   localparam int CTRL_CONT   = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_ABORT  = 3;

   // TIMING byte fields
   localparam int TIM_RST_LSB = 0;
   localparam int TIM_INT_LSB = 8;
   localparam int TIM_SH_LSB  = 16;
   localparam int TIM_CMP_LSB = 24;

   // STATUS fields
   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_OVR      = 2;
   localparam int STAT_FCNT_LSB = 16;

   localparam logic [31:0] TIMING_RST = 32'h0101_0101;

   // A programmed length of 0 still gives a one-cycle phase
   function automatic logic [7:0] phase_len(input logic [7:0] t);
      return (t == 8'd0) ? 8'd1 : t;
   endfunction

endpackage

// File: rtl/rlbp_seq_if.sv
// Wishbone classic slave bus bundle for the RLBP sequencer.
// Latency: n/a (wiring only).
// Backpressure: slave stalls the master by withholding wbs_ack_o.
interface rlbp_seq_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_dat_o, wbs_ack_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_dat_o, wbs_ack_o
   );
endinterface

// File: rtl/rlbp_wb_regs.sv
// Wishbone register file: CTRL/TIMING/STATUS/CODE, W1 pulses, W1C sticky flags.
// Latency: ack and read data one cycle after cyc&stb; write effects visible on the ack edge.
// Backpressure: none; every in-window access acks after one cycle, ack drops for a cycle between accesses.
// Ports: clk/rst, wb (Wishbone slave), busy/frame_done/code_in from the sequencer,
//        timing/start/abort/cont/irq_en control out, irq level out.
module rlbp_wb_regs
   import rlbp_pkg::*;
#(
   parameter int          N_CH     = 12,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic            clk,
   input  logic            rst,
   rlbp_seq_if.slave       wb,
   input  logic            busy,
   input  logic            frame_done,
   input  logic [N_CH-1:0] code_in,
   output logic [31:0]     timing,
   output logic            start,
   output logic            abort,
   output logic            cont,
   output logic            irq_en,
   output logic            irq
);

   logic            ack_q;
   logic [31:0]     dat_q;
   logic [31:0]     rd_dat;
   logic            start_q, abort_q, cont_q, irq_en_q;
   logic [31:0]     timing_q;
   logic            done_q, ovr_q;
   logic [15:0]     fcnt_q;
   logic [N_CH-1:0] code_q;

   logic       hit, acc, wr, rd;
   logic [1:0] rsel;
   logic       wr_ctrl, wr_timing, wr_status;
   logic       w1c_done, w1c_ovr;
   logic       unused_adr;

   assign hit  = (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
   // ~ack_q forces an idle cycle between acks on a held strobe
   assign acc  = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_q;
   assign wr   = acc & wb.wbs_we_i;
   assign rd   = acc & ~wb.wbs_we_i;
   assign rsel = wb.wbs_adr_i[3:2];
   assign unused_adr = &{1'b0, wb.wbs_adr_i[1:0]};

   assign wr_ctrl   = wr && (rsel == REG_CTRL)   && wb.wbs_sel_i[0];
   assign wr_timing = wr && (rsel == REG_TIMING);
   assign wr_status = wr && (rsel == REG_STATUS) && wb.wbs_sel_i[0];
   assign w1c_done  = wr_status & wb.wbs_dat_i[STAT_DONE];
   assign w1c_ovr   = wr_status & wb.wbs_dat_i[STAT_OVR];

   always_comb begin
      rd_dat = '0;
      case (rsel)
         REG_CTRL: begin
            rd_dat[CTRL_CONT]   = cont_q;
            rd_dat[CTRL_IRQ_EN] = irq_en_q;
         end
         REG_TIMING: rd_dat = timing_q;
         REG_STATUS: begin
            rd_dat[STAT_BUSY]            = busy;
            rd_dat[STAT_DONE]            = done_q;
            rd_dat[STAT_OVR]             = ovr_q;
            rd_dat[STAT_FCNT_LSB +: 16]  = fcnt_q;
         end
         REG_CODE: rd_dat[N_CH-1:0] = code_q;
         default: rd_dat = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         start_q  <= 1'b0;
         abort_q  <= 1'b0;
         cont_q   <= 1'b0;
         irq_en_q <= 1'b0;
         timing_q <= TIMING_RST;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         fcnt_q   <= '0;
         code_q   <= '0;
      end else begin
         ack_q   <= acc;
         dat_q   <= rd ? rd_dat : '0;
         // A start written while a frame runs (even in its last cycle) is dropped
         start_q <= wr_ctrl & wb.wbs_dat_i[CTRL_START] & ~busy;
         abort_q <= wr_ctrl & wb.wbs_dat_i[CTRL_ABORT];
         if (wr_ctrl) begin
            cont_q   <= wb.wbs_dat_i[CTRL_CONT];
            irq_en_q <= wb.wbs_dat_i[CTRL_IRQ_EN];
         end
         for (int b = 0; b < 4; b++) begin
            if (wr_timing && wb.wbs_sel_i[b])
               timing_q[8*b +: 8] <= wb.wbs_dat_i[8*b +: 8];
         end
         // Frame-done sets beat a same-edge W1C; overrun looks at done before this edge
         done_q <= frame_done | (done_q & ~w1c_done);
         ovr_q  <= (frame_done & done_q) | (ovr_q & ~w1c_ovr);
         if (frame_done) begin
            code_q <= code_in;
            fcnt_q <= fcnt_q + 16'd1;
         end
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
   assign timing       = timing_q;
   assign start        = start_q;
   assign abort        = abort_q;
   assign cont         = cont_q;
   assign irq_en       = irq_en_q;
   assign irq          = done_q & irq_en_q;

endmodule

// File: rtl/rlbp_seq.sv
// RLBP pixel-readout sequencer: RST/INT/SH/CMP phase strobes, comparator code capture.
// Latency: start ack edge n -> RST at n+1; frame = sum of max(t_x,1); cmp_i->CODE via 2-flop sync.
// Backpressure: none on the macro side; Wishbone side acks every in-window access after one cycle.
// Ports: wb_clk_i/wb_rst_i, wbs (Wishbone slave), cmp_i comparators in,
//        sh_rst_o/sw1_o/sh_o/sw2_o/sh_cmp_o strobes out, irq_o level interrupt.
module rlbp_seq
   import rlbp_pkg::*;
#(
   parameter int          N_CH     = 12,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   rlbp_seq_if.slave       wbs,
   input  logic [N_CH-1:0] cmp_i,
   output logic            sh_rst_o,
   output logic            sw1_o,
   output logic            sh_o,
   output logic            sw2_o,
   output logic            sh_cmp_o,
   output logic            irq_o
);

   logic [31:0]     timing;
   logic            start, abort, cont, irq_en;
   logic            busy, frame_done, last;
   state_t          state_q, state_nxt;
   logic [7:0]      cnt_q, cnt_nxt;
   strobes_t        stb_q, stb_nxt;
   logic [N_CH-1:0] cmp_s1, cmp_s2;

   rlbp_wb_regs #(.N_CH(N_CH), .BASE_ADR(BASE_ADR)) u_regs (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .wb         (wbs),
      .busy       (busy),
      .frame_done (frame_done),
      .code_in    (cmp_s2),
      .timing     (timing),
      .start      (start),
      .abort      (abort),
      .cont       (cont),
      .irq_en     (irq_en),
      .irq        (irq_o)
   );

   // Comparator synchroniser
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cmp_s1 <= '0;
         cmp_s2 <= '0;
      end else begin
         cmp_s1 <= cmp_i;
         cmp_s2 <= cmp_s1;
      end
   end

   // State register, phase counter and registered strobes
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         stb_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         stb_q   <= stb_nxt;
      end
   end

   assign last       = (cnt_q == 8'd1);
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = (state_q == ST_CMP) & last & ~abort;

   // Next state and counter; the counter reloads from TIMING on every phase entry
   always_comb begin
      state_nxt = state_q;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) state_nxt = ST_RST;
            ST_RST:  if (last)  state_nxt = ST_INT;
            ST_INT:  if (last)  state_nxt = ST_SH;
            ST_SH:   if (last)  state_nxt = ST_CMP;
            ST_CMP:  if (last)  state_nxt = cont ? ST_RST : ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end

      cnt_nxt = cnt_q - 8'd1;
      if (state_nxt == ST_IDLE) begin
         cnt_nxt = '0;
      end else if (state_nxt != state_q) begin
         case (state_nxt)
            ST_RST:  cnt_nxt = phase_len(timing[TIM_RST_LSB +: 8]);
            ST_INT:  cnt_nxt = phase_len(timing[TIM_INT_LSB +: 8]);
            ST_SH:   cnt_nxt = phase_len(timing[TIM_SH_LSB  +: 8]);
            ST_CMP:  cnt_nxt = phase_len(timing[TIM_CMP_LSB +: 8]);
            default: cnt_nxt = '0;
         endcase
      end
   end

   // Strobes decode the next state so the registered pins line up with state_q
   always_comb begin
      stb_nxt = '0;
      case (state_nxt)
         ST_RST: stb_nxt.sh_rst = 1'b1;
         ST_INT: stb_nxt.sw1    = 1'b1;
         ST_SH: begin
            stb_nxt.sh  = 1'b1;
            stb_nxt.sw2 = 1'b1;
         end
         ST_CMP: stb_nxt.sh_cmp = 1'b1;
         default: stb_nxt = '0;
      endcase
   end

   assign sh_rst_o = stb_q.sh_rst;
   assign sw1_o    = stb_q.sw1;
   assign sh_o     = stb_q.sh;
   assign sw2_o    = stb_q.sw2;
   assign sh_cmp_o = stb_q.sh_cmp;

endmodule

// File: tb/tb_rlbp_seq.sv
// Directed bench for rlbp_seq with a queue of expected results.
// Latency: n/a.
// Backpressure: n/a.
module tb_rlbp_seq;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] A_CTRL   = BASE + 32'h0;
   localparam logic [31:0] A_TIMING = BASE + 32'h4;
   localparam logic [31:0] A_STATUS = BASE + 32'h8;
   localparam logic [31:0] A_CODE   = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] cmp = '0;
   logic        sh_rst_o, sw1_o, sh_o, sw2_o, sh_cmp_o, irq_o;
   logic [4:0]  strb;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   rlbp_seq_if wbif();

   rlbp_seq #(.N_CH(12), .BASE_ADR(BASE)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (wbif),
      .cmp_i    (cmp),
      .sh_rst_o (sh_rst_o),
      .sw1_o    (sw1_o),
      .sh_o     (sh_o),
      .sw2_o    (sw2_o),
      .sh_cmp_o (sh_cmp_o),
      .irq_o    (irq_o)
   );

   always #5 clk = ~clk;
   assign strb = {sh_rst_o, sw1_o, sh_o, sw2_o, sh_cmp_o};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
      bit got;
      got = 1'b0;
      wbif.wbs_cyc_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_we_i = 1'b1;
      wbif.wbs_adr_i = adr;  wbif.wbs_dat_i = dat;  wbif.wbs_sel_i = sel;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (wbif.wbs_ack_o) begin got = 1'b1; break; end
      end
      check({tag, " ack"}, {31'b0, got}, 32'd1);
      wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0; wbif.wbs_we_i = 1'b0;
   endtask

   task automatic wb_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      bit got;
      logic [31:0] e;
      got = 1'b0;
      exp_q.push_back(exp);
      wbif.wbs_cyc_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_we_i = 1'b0;
      wbif.wbs_adr_i = adr;  wbif.wbs_sel_i = 4'hF;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (wbif.wbs_ack_o) begin got = 1'b1; break; end
      end
      e = exp_q.pop_front();
      if (got) check(tag, wbif.wbs_dat_o, e);
      else     check({tag, " ack timeout"}, {31'b0, got}, 32'd1);
      wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0;
   endtask

   // Call right after the start write returns; counts strobe-high cycles until idle
   task automatic run_frame(input string tag, input int e_rst, input int e_int,
                            input int e_sh, input int e_cmp);
      int n_rst, n_int, n_sh, n_cmp, split, total;
      n_rst = 0; n_int = 0; n_sh = 0; n_cmp = 0; split = 0; total = 0;
      exp_q.push_back(e_rst);
      exp_q.push_back(e_int);
      exp_q.push_back(e_sh);
      exp_q.push_back(e_cmp);
      exp_q.push_back(e_rst + e_int + e_sh + e_cmp);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (i == 0) check({tag, " first cycle strobes"}, {27'b0, strb}, 32'h10);
         if (strb == 5'b0 && total > 0) break;
         if (strb != 5'b0) total++;
         if (sh_rst_o) n_rst++;
         if (sw1_o)    n_int++;
         if (sh_o)     n_sh++;
         if (sh_cmp_o) n_cmp++;
         if (sh_o != sw2_o) split++;
      end
      check({tag, " sh_rst cycles"}, n_rst, exp_q.pop_front());
      check({tag, " sw1 cycles"},    n_int, exp_q.pop_front());
      check({tag, " sh cycles"},     n_sh,  exp_q.pop_front());
      check({tag, " sh_cmp cycles"}, n_cmp, exp_q.pop_front());
      check({tag, " frame cycles"},  total, exp_q.pop_front());
      check({tag, " sh/sw2 differ"}, split, 32'd0);
   endtask

   task automatic wait_sw1(input string tag);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (sw1_o) break;
      end
      check({tag, " reached INT"}, {31'b0, sw1_o}, 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " strobes"}, {27'b0, strb}, 32'd0);
      check({tag, " irq_o"},   {31'b0, irq_o}, 32'd0);
      check({tag, " ack"},     {31'b0, wbif.wbs_ack_o}, 32'd0);
      check({tag, " dat_o"},   wbif.wbs_dat_o, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int first_irq, acks;
      wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0; wbif.wbs_we_i = 1'b0;
      wbif.wbs_sel_i = 4'h0; wbif.wbs_adr_i = '0;   wbif.wbs_dat_i = '0;

      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("por");
      rst = 1'b0;
      @(posedge clk); #1;
      wb_read("por STATUS", A_STATUS, 32'h0);
      wb_read("por CODE",   A_CODE,   32'h0);
      wb_read("por TIMING", A_TIMING, 32'h0101_0101);
      wb_read("por CTRL",   A_CTRL,   32'h0);

      // Held strobe: ack pulses every other cycle
      acks = 0;
      wbif.wbs_cyc_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_we_i = 1'b0;
      wbif.wbs_adr_i = A_TIMING;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (wbif.wbs_ack_o) acks++;
      end
      wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0;
      check("held strobe ack count", acks, 32'd2);

      // Single frame with uneven phases
      wb_write("tim 302", A_TIMING, 32'h0101_0302, 4'hF);
      cmp = 12'hA5A;
      repeat (3) @(posedge clk);
      #1;
      wb_write("start1", A_CTRL, 32'h1, 4'hF);
      run_frame("frame1", 2, 3, 1, 1);
      wb_read("frame1 CODE",   A_CODE,   32'h0000_0A5A);
      wb_read("frame1 STATUS", A_STATUS, 32'h0001_0002);
      check("frame1 irq disabled", {31'b0, irq_o}, 32'd0);
      wb_write("w1c done", A_STATUS, 32'h2, 4'hF);
      wb_read("after w1c STATUS", A_STATUS, 32'h0001_0000);

      // Byte enables
      wb_write("tim byte0", A_TIMING, 32'hFFFF_FFFF, 4'b0001);
      wb_read("tim byte0 rd", A_TIMING, 32'h0101_03FF);

      // All-zero timing: one cycle per phase
      cmp = 12'h3C5;
      wb_write("tim 0", A_TIMING, 32'h0, 4'hF);
      wb_write("start2", A_CTRL, 32'h1, 4'hF);
      run_frame("frame2", 1, 1, 1, 1);
      wb_read("frame2 CODE",   A_CODE,   32'h0000_03C5);
      wb_read("frame2 STATUS", A_STATUS, 32'h0002_0002);
      wb_write("w1c done2", A_STATUS, 32'h2, 4'hF);

      // Abort during INT
      wb_write("tim long int", A_TIMING, 32'h0101_2001, 4'hF);
      cmp = 12'hFFF;
      wb_write("start3", A_CTRL, 32'h1, 4'hF);
      wait_sw1("abort");
      wb_write("abort", A_CTRL, 32'h8, 4'hF);
      @(posedge clk); #1;
      check("abort strobes", {27'b0, strb}, 32'd0);
      wb_read("abort CODE",   A_CODE,   32'h0000_03C5);
      wb_read("abort STATUS", A_STATUS, 32'h0002_0000);

      // Abort and start together: stays idle
      wb_write("abort+start", A_CTRL, 32'h9, 4'hF);
      repeat (2) @(posedge clk);
      #1;
      check("abort+start strobes", {27'b0, strb}, 32'd0);
      wb_read("abort+start STATUS", A_STATUS, 32'h0002_0000);

      // Continuous frames, irq enabled, done never cleared
      wb_write("tim 1111", A_TIMING, 32'h0101_0101, 4'hF);
      cmp = 12'h0F0;
      repeat (3) @(posedge clk);
      #1;
      wb_write("start cont", A_CTRL, 32'h7, 4'hF);
      first_irq = 0;
      for (int j = 1; j <= 21; j++) begin
         @(posedge clk); #1;
         if (irq_o && first_irq == 0) first_irq = j;
      end
      check("cont irq after frame1", first_irq, 32'd5);
      wb_write("clear cont", A_CTRL, 32'h4, 4'hF);
      wb_read("cont STATUS 5 frames", A_STATUS, 32'h0007_0007);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (strb == 5'b0) break;
      end
      check("cont stop idle", {27'b0, strb}, 32'd0);
      wb_read("cont stop STATUS", A_STATUS, 32'h0008_0006);
      wb_read("cont CODE",        A_CODE,   32'h0000_00F0);
      check("irq level held", {31'b0, irq_o}, 32'd1);
      wb_write("w1c done+ovr", A_STATUS, 32'h6, 4'hF);
      check("irq after w1c", {31'b0, irq_o}, 32'd0);
      wb_read("cleared STATUS", A_STATUS, 32'h0008_0000);

      // W1C of done on the frame-done edge: set wins
      cmp = 12'h55A;
      repeat (3) @(posedge clk);
      #1;
      wb_write("start race", A_CTRL, 32'h1, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      wb_write("w1c on done edge", A_STATUS, 32'h2, 4'hF);
      wb_read("race STATUS", A_STATUS, 32'h0009_0002);
      wb_read("race CODE",   A_CODE,   32'h0000_055A);

      // Outside the window: never acked
      acks = 0;
      wbif.wbs_cyc_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_we_i = 1'b0;
      wbif.wbs_adr_i = BASE + 32'h40;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wbif.wbs_ack_o) acks++;
      end
      wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0;
      check("out of window ack", acks, 32'd0);

      // Reset mid-frame
      wb_write("tim mid rst", A_TIMING, 32'h0101_2001, 4'hF);
      wb_write("start irq", A_CTRL, 32'h5, 4'hF);
      wait_sw1("midrst");
      check("pre-reset irq", {31'b0, irq_o}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      wb_read("midrst STATUS", A_STATUS, 32'h0);
      wb_read("midrst CODE",   A_CODE,   32'h0);
      wb_read("midrst TIMING", A_TIMING, 32'h0101_0101);
      wb_read("midrst CTRL",   A_CTRL,   32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
